// File: rtl/param_fifo_pkg.sv
// Shared types and helpers for the parameterised synchronous FIFO.
package param_fifo_pkg;

    // Per-cycle operation actually accepted by the FIFO: {read, write}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_WR   = 2'b01,
        OP_RD   = 2'b10,
        OP_RW   = 2'b11
    } fifo_op_e;

    // Circular pointer increment for depths that need not be a power of two.
    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage : param_fifo_pkg

// File: rtl/param_fifo_ram.sv
// Simple dual-port RAM: one write port and a registered, hold-on-idle read port.
module param_fifo_ram #(
    parameter  int unsigned WIDTH_DATA = 8,
    parameter  int unsigned NUMWORDS   = 16,
    localparam int unsigned AW         = $clog2(NUMWORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [AW-1:0]         wr_addr_i,
    input  logic [WIDTH_DATA-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [AW-1:0]         rd_addr_i,
    output logic [WIDTH_DATA-1:0] rd_data_o
);

    logic [WIDTH_DATA-1:0] mem_q [NUMWORDS];
    logic [WIDTH_DATA-1:0] rd_data_q;

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule : param_fifo_ram

// File: rtl/param_fifo.sv
// Parameterised single-clock FIFO: pointers, occupancy, flags and optional output stage.
module param_fifo
    import param_fifo_pkg::*;
#(
    parameter  int unsigned WIDTH_DATA = 8,
    parameter  int unsigned NUMWORDS   = 16,
    parameter  int unsigned REG_OUT    = 0,
    localparam int unsigned CW         = $clog2(NUMWORDS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [WIDTH_DATA-1:0] wr_data,
    input  logic                  rd_en,
    output logic [WIDTH_DATA-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [CW-1:0]         usedw
);

    localparam int unsigned AW = $clog2(NUMWORDS);

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         usedw_q, usedw_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  wr_acc_c;
    logic                  rd_acc_c;
    fifo_op_e              op_c;
    logic [WIDTH_DATA-1:0] ram_rd_data;

    // Requests are qualified against the registered flags only.
    assign wr_acc_c = wr_en && !full_q;
    assign rd_acc_c = rd_en && !empty_q;
    assign op_c     = fifo_op_e'({rd_acc_c, wr_acc_c});

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        usedw_d  = usedw_q;
        if (wr_acc_c) begin
            wr_ptr_d = AW'(wrap_inc(32'(wr_ptr_q), NUMWORDS));
        end
        if (rd_acc_c) begin
            rd_ptr_d = AW'(wrap_inc(32'(rd_ptr_q), NUMWORDS));
        end
        case (op_c)
            OP_WR:   usedw_d = usedw_q + CW'(1);
            OP_RD:   usedw_d = usedw_q - CW'(1);
            default: usedw_d = usedw_q;
        endcase
        full_d  = (usedw_d == CW'(NUMWORDS));
        empty_d = (usedw_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usedw_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            usedw_q  <= usedw_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    param_fifo_ram #(
        .WIDTH_DATA (WIDTH_DATA),
        .NUMWORDS   (NUMWORDS)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_acc_c),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wr_data),
        .rd_en_i   (rd_acc_c),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (ram_rd_data)
    );

    // Optional retiming stage; it simply follows the RAM output one clock later.
    if (REG_OUT != 0) begin : g_reg_out
        logic [WIDTH_DATA-1:0] out_q;
        always_ff @(posedge clk) begin
            if (!rst) begin
                out_q <= '0;
            end else begin
                out_q <= ram_rd_data;
            end
        end
        assign rd_data = out_q;
    end else begin : g_no_reg_out
        assign rd_data = ram_rd_data;
    end

    assign full  = full_q;
    assign empty = empty_q;
    assign usedw = usedw_q;

endmodule : param_fifo

// File: tb/tb_param_fifo.sv
// Scoreboard bench: three FIFO configurations share stimulus, each checked against a queue model.
module tb_param_fifo;

    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] wr_data;

    logic [7:0] rd0, rd1, rd2;
    logic       full0, full1, full2;
    logic       empty0, empty1, empty2;
    logic [4:0] usedw0, usedw1;
    logic [2:0] usedw2;

    always #5 clk = ~clk;

    param_fifo #(.WIDTH_DATA(8), .NUMWORDS(16), .REG_OUT(0)) u_dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd0), .full(full0), .empty(empty0), .usedw(usedw0)
    );
    param_fifo #(.WIDTH_DATA(8), .NUMWORDS(16), .REG_OUT(1)) u_dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd1), .full(full1), .empty(empty1), .usedw(usedw1)
    );
    param_fifo #(.WIDTH_DATA(8), .NUMWORDS(5), .REG_OUT(1)) u_dut2 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd2), .full(full2), .empty(empty2), .usedw(usedw2)
    );

    // Per-configuration views of the DUT outputs.
    logic [7:0]  rd_a    [NI];
    logic        full_a  [NI];
    logic        empty_a [NI];
    int unsigned usedw_a [NI];
    assign rd_a[0] = rd0;  assign rd_a[1] = rd1;  assign rd_a[2] = rd2;
    assign full_a[0] = full0;  assign full_a[1] = full1;  assign full_a[2] = full2;
    assign empty_a[0] = empty0;  assign empty_a[1] = empty1;  assign empty_a[2] = empty2;
    assign usedw_a[0] = 32'(usedw0);  assign usedw_a[1] = 32'(usedw1);  assign usedw_a[2] = 32'(usedw2);

    typedef struct packed {
        logic [31:0] due;
        logic [7:0]  data;
    } exp_t;

    int unsigned depth [NI] = '{16, 16, 5};
    int unsigned lat   [NI] = '{1, 2, 2};

    logic [7:0]  mq [NI][$];
    exp_t        eq [NI][$];
    logic [7:0]  exp_rd [NI];

    int unsigned step_n  = 0;
    int unsigned edge_n  = 0;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Drive one cycle of stimulus and advance the reference model to the post-edge state.
    task automatic step(input logic r, input logic w, input logic rd, input logic [7:0] d);
        exp_t e;
        rst     = r;
        wr_en   = w;
        rd_en   = rd;
        wr_data = d;
        step_n++;
        for (int i = 0; i < NI; i++) begin
            if (!r) begin
                mq[i].delete();
                eq[i].delete();
                e.due  = step_n;
                e.data = 8'h00;
                eq[i].push_back(e);
            end else begin
                bit do_rd;
                bit do_wr;
                do_rd = rd && (mq[i].size() > 0);
                do_wr = w && (mq[i].size() < depth[i]);
                if (do_rd) begin
                    e.due  = step_n + lat[i] - 1;
                    e.data = mq[i].pop_front();
                    eq[i].push_back(e);
                end
                if (do_wr) mq[i].push_back(d);
            end
        end
        @(negedge clk);
    endtask

    // Monitor: retire due words from the scoreboard and compare every output each edge.
    initial begin
        for (int i = 0; i < NI; i++) exp_rd[i] = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            edge_n++;
            for (int i = 0; i < NI; i++) begin
                while (eq[i].size() > 0 && eq[i][0].due <= edge_n) begin
                    exp_rd[i] = eq[i][0].data;
                    void'(eq[i].pop_front());
                end
                chk($sformatf("rd_data[%0d]", i), 32'(rd_a[i]), 32'(exp_rd[i]));
                chk($sformatf("usedw[%0d]", i), usedw_a[i], mq[i].size());
                chk($sformatf("full[%0d]", i), 32'(full_a[i]), 32'(mq[i].size() == depth[i]));
                chk($sformatf("empty[%0d]", i), 32'(empty_a[i]), 32'(mq[i].size() == 0));
            end
        end
    end

    task automatic run_mix(input int wsel, input int rsel);
        int unsigned wp;
        int unsigned rp;
        wp = 50;
        rp = 50;
        for (int c = 0; c < 5000; c++) begin
            if (c % 250 == 0) begin
                wp = (wsel < 0) ? $urandom_range(100) : wsel;
                rp = (rsel < 0) ? $urandom_range(100) : rsel;
            end
            step(1'b1, $urandom_range(99) < wp, $urandom_range(99) < rp, 8'($urandom));
        end
    endtask

    initial begin
        // Reset held for five clocks.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("reset_usedw", 32'(usedw0), 0);
        chk("reset_empty", 32'(empty0), 1);
        chk("reset_full", 32'(full0), 0);
        chk("reset_rd_data_lat1", 32'(rd0), 0);
        chk("reset_rd_data_lat2", 32'(rd1), 0);

        // Fill then drain.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, 8'(i));
        chk("fill_usedw", 32'(usedw0), 16);
        chk("fill_full", 32'(full0), 1);
        chk("fill_usedw_depth5", 32'(usedw2), 5);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b1, 8'h00);
        chk("drain_last_word", 32'(rd0), 32'h0F);
        chk("drain_empty", 32'(empty0), 1);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("drain_last_word_lat2", 32'(rd1), 32'h0F);

        // Overflow while full, then underflow while empty.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h10 + i));
        step(1'b1, 1'b1, 1'b0, 8'hAA);
        chk("overflow_usedw", 32'(usedw0), 16);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b1, 8'h00);
        chk("overflow_last_word", 32'(rd0), 32'h1F);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        chk("underflow_rd_hold", 32'(rd0), 32'h1F);
        chk("underflow_usedw", 32'(usedw0), 0);

        // Simultaneous read and write, mid-level and at full.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h20 + i));
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 8'(8'h30 + i));
        chk("rw_mid_usedw", 32'(usedw0), 5);
        for (int i = 0; i < 11; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h40 + i));
        chk("rw_prefull", 32'(full0), 1);
        step(1'b1, 1'b1, 1'b1, 8'hBB);
        chk("rw_full_usedw", 32'(usedw0), 15);
        chk("rw_full_flag", 32'(full0), 0);
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 1'b1, 8'h00);
        chk("rw_drain_empty", 32'(empty0), 1);

        // Reset in the middle of a stream.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h50 + i));
        chk("midrst_pre_usedw", 32'(usedw0), 7);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("midrst_usedw", 32'(usedw0), 0);
        chk("midrst_empty", 32'(empty0), 1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 8'h00);
        chk("midrst_no_old_data", 32'(rd0), 0);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h60 + i));
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b1, 8'h00);
        chk("midrst_new_data", 32'(rd0), 32'h61);

        // Random traffic mixes; negative percentage means re-drawn periodically.
        run_mix(50, 50);
        run_mix(-1, -1);
        run_mix(100, -1);
        run_mix(-1, 100);
        run_mix(100, 100);

        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < NI; i++) chk($sformatf("pending[%0d]", i), eq[i].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_param_fifo
